// File: rtl/res_bcd_fmt_pkg.sv
// Shared definitions for the result-to-BCD formatter: FSM state
// encoding, the blank digit code and the double-dabble threshold.
package res_fmt_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE,
    ABS,
    SHIFT,
    FIN
  } fmt_state_t;

  // Digit code the seven-segment driver renders as an unlit digit
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Double-dabble correction threshold: digits at or above this get +3
  localparam logic [3:0] DD_ADJ_TH = 4'd5;

endpackage

// File: rtl/res_bcd_fmt_dd_digit_adj.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or
// more, so the following left shift carries correctly into the next digit.
import res_fmt_pkg::*;

module dd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3-if-at-least-5 correction
  always_comb begin
    dout = din;
    if (din >= DD_ADJ_TH) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/res_bcd_fmt.sv
// Result formatter: captures a signed ALU result on res_vld, takes its
// magnitude, converts it to ND BCD digits with a bit-serial double-dabble
// and presents sign, overflow error and digits to the display driver.
// Optional build macro RES_BCD_FMT_BLANK_EN: blank leading zero digits
// (and show all-blank on overflow) instead of raw BCD.
import res_fmt_pkg::*;

module res_bcd_fmt #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_vld,
  input  logic [W-1:0]    res,
  input  logic            ovf,
  output logic            busy,
  output logic            out_vld,
  output logic            neg,
  output logic            err,
  output logic [4*ND-1:0] bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * ND;

`ifdef RES_BCD_FMT_BLANK_EN
  localparam logic [BW-1:0] ERR_CODE = {ND{BCD_BLANK}};
`else
  localparam logic [BW-1:0] ERR_CODE = '0;
`endif

  fmt_state_t    state_q, state_d;
  logic [W-1:0]  mag_q, mag_d;
  logic [BW-1:0] scratch_q, scratch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;

  logic [BW-1:0]   scratch_adj;
  logic [BW+W-1:0] dd_vec;
  logic [BW+W-1:0] dd_shift;
  logic [BW-1:0]   scratch_shift;
  logic [W-1:0]    mag_shift;
  logic [BW-1:0]   bcd_fmt;

  // One corrector per digit of the BCD scratch register
  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_adj
      dd_digit_adj u_adj (
        .din  (scratch_q[4*g +: 4]),
        .dout (scratch_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected scratch and magnitude shifted left together as one word
  always_comb begin
    dd_vec        = {scratch_adj, mag_q};
    dd_shift      = dd_vec << 1;
    scratch_shift = dd_shift[BW+W-1:W];
    mag_shift     = dd_shift[W-1:0];
  end

`ifdef RES_BCD_FMT_BLANK_EN
  // Blank leading zero digits from the top down; digit 0 always shows
  always_comb begin
    logic leading;
    bcd_fmt = scratch_shift;
    leading = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      if (leading && (scratch_shift[4*i +: 4] == 4'd0)) begin
        bcd_fmt[4*i +: 4] = BCD_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  // Raw BCD digits including leading zeros
  always_comb begin
    bcd_fmt = scratch_shift;
  end
`endif

  // State and datapath registers; reset wins over any conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath updates; outputs load on entry to FIN so
  // they are already valid during the FIN cycle alongside out_vld
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (res_vld) begin
          if (ovf) begin
            err_d   = 1'b1;
            neg_d   = 1'b0;
            bcd_d   = ERR_CODE;
            state_d = FIN;
          end else begin
            mag_d   = res;
            sign_d  = res[W-1];
            state_d = ABS;
          end
        end
      end

      ABS: begin
        if (sign_q) begin
          mag_d = ~mag_q + {{(W-1){1'b0}}, 1'b1};
        end
        scratch_d = '0;
        cnt_d     = CW'(W);
        state_d   = SHIFT;
      end

      SHIFT: begin
        scratch_d = scratch_shift;
        mag_d     = mag_shift;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = bcd_fmt;
          neg_d   = sign_q;
          err_d   = 1'b0;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status and result outputs
  always_comb begin
    busy    = (state_q != IDLE);
    out_vld = (state_q == FIN);
    neg     = neg_q;
    err     = err_q;
    bcd     = bcd_q;
  end

endmodule
